// File: rtl/axi_dma_rd.sv
// axi_dma_rd: AXI4 read-master DMA. Fetches num_trans 32-bit words starting at
// start_addr as INCR bursts of FIXED_BURST_SIZE beats (shorter final burst) and
// streams them to a local consumer; one burst outstanding at a time.
// Latency: start_dma at cycle N -> M_ARVALID at N+2; data_last_o 1 cycle after final beat.
// Backpressure: M_RREADY follows outdata_ready_i combinationally while bursting.
// Ports: clk/rstn (async active-low); M_AR* address channel; M_R* data channel;
//   start_dma/num_trans/start_addr command; outdata/outdata_valid_o/outdata_ready_i
//   consumer stream; data_last_o completion pulse; busy_o; err_o.
// Optional: define AXI_DMA_RD_ERR_CHK_EN to build the RRESP/RLAST checker driving
//   err_o; otherwise err_o is tied 0.
module axi_dma_rd #(
  parameter int M_AXI_ID_WIDTH   = 4,
  parameter int M_AXI_ADDR_WIDTH = 32,
  parameter int M_AXI_DATA_WIDTH = 32,
  parameter int BITS_TRANS       = 18,
  parameter int FIXED_BURST_SIZE = 16,
  parameter int M_W              = 2
) (
  input  logic                        clk,
  input  logic                        rstn,
  output logic [M_AXI_ID_WIDTH-1:0]   M_ARID,
  output logic [M_AXI_ADDR_WIDTH-1:0] M_ARADDR,
  output logic [7:0]                  M_ARLEN,
  output logic [2:0]                  M_ARSIZE,
  output logic [1:0]                  M_ARBURST,
  output logic [1:0]                  M_ARLOCK,
  output logic [3:0]                  M_ARCACHE,
  output logic [2:0]                  M_ARPROT,
  output logic [3:0]                  M_ARREGION,
  output logic [3:0]                  M_ARQOS,
  output logic                        M_ARVALID,
  input  logic                        M_ARREADY,
  input  logic [M_AXI_ID_WIDTH-1:0]   M_RID,
  input  logic [M_AXI_DATA_WIDTH-1:0] M_RDATA,
  input  logic [1:0]                  M_RRESP,
  input  logic                        M_RLAST,
  input  logic                        M_RVALID,
  output logic                        M_RREADY,
  input  logic                        start_dma,
  input  logic [BITS_TRANS-1:0]       num_trans,
  input  logic [M_AXI_ADDR_WIDTH-1:0] start_addr,
  output logic [M_AXI_DATA_WIDTH-1:0] outdata,
  output logic                        outdata_valid_o,
  input  logic                        outdata_ready_i,
  output logic                        data_last_o,
  output logic                        busy_o,
  output logic                        err_o
);

  typedef enum logic [1:0] {RD_IDLE, RD_PRE, RD_START, RD_SEQ} state_t;

  localparam logic [BITS_TRANS-1:0] FBS_T = BITS_TRANS'(FIXED_BURST_SIZE);
  localparam logic [8:0]            FBS_9 = 9'(FIXED_BURST_SIZE);

  state_t                      state;
  logic [BITS_TRANS-1:0]       num_trans_d;
  logic [BITS_TRANS-1:0]       burst_cnt;
  logic [BITS_TRANS-1:0]       remain;
  logic [BITS_TRANS-1:0]       burst_cnt_nxt;
  logic [M_AXI_ADDR_WIDTH-1:0] addr_q;
  logic [8:0]                  burst_len_q;
  logic [8:0]                  burst_len_d;
  logic [8:0]                  len_m1;
  logic [7:0]                  beat_cnt;
  logic                        arvalid_q;
  logic                        last_q;
  logic                        in_seq;
  logic                        beat;
  logic                        beat_end;
  logic                        last_beat;

  // Size of the next burst: a full burst, or whatever is left over.
  assign remain        = num_trans_d - burst_cnt;
  assign burst_len_d   = (remain >= FBS_T) ? FBS_9 : remain[8:0];
  assign len_m1        = burst_len_q - 9'd1;
  assign burst_cnt_nxt = burst_cnt + BITS_TRANS'(burst_len_q);

  assign in_seq    = (state == RD_SEQ);
  assign beat      = in_seq && M_RVALID && outdata_ready_i;
  // Bursts end on the beat count; RLAST is only cross-checked by the error logic.
  assign beat_end  = ({1'b0, beat_cnt} == len_m1);
  assign last_beat = beat && beat_end;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= RD_IDLE;
      num_trans_d <= '0;
      burst_cnt   <= '0;
      addr_q      <= '0;
      burst_len_q <= '0;
      beat_cnt    <= '0;
      arvalid_q   <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      burst_len_q <= burst_len_d;
      last_q      <= 1'b0;
      case (state)
        RD_IDLE: begin
          if (start_dma) begin
            num_trans_d <= num_trans;
            addr_q      <= start_addr;
            burst_cnt   <= '0;
            beat_cnt    <= '0;
            // Empty transfer: completion pulse lands in the RD_PRE cycle.
            last_q      <= (num_trans == '0);
            state       <= RD_PRE;
          end
        end
        RD_PRE: begin
          if (burst_cnt == num_trans_d) begin
            burst_cnt <= '0;
            state     <= RD_IDLE;
          end else begin
            arvalid_q <= 1'b1;
            state     <= RD_START;
          end
        end
        RD_START: begin
          if (M_ARREADY) begin
            arvalid_q <= 1'b0;
            state     <= RD_SEQ;
          end
        end
        RD_SEQ: begin
          if (last_beat) begin
            beat_cnt  <= '0;
            burst_cnt <= burst_cnt_nxt;
            addr_q    <= addr_q + (M_AXI_ADDR_WIDTH'(burst_len_q) << M_W);
            // Registered so the pulse coincides with the following RD_PRE cycle.
            last_q    <= (burst_cnt_nxt == num_trans_d);
            state     <= RD_PRE;
          end else if (beat) begin
            beat_cnt <= beat_cnt + 8'd1;
          end
        end
        default: state <= RD_IDLE;
      endcase
    end
  end

  assign M_ARID     = '0;
  assign M_ARADDR   = arvalid_q ? addr_q : '0;
  assign M_ARLEN    = arvalid_q ? len_m1[7:0] : 8'd0;
  assign M_ARSIZE   = 3'(M_W);
  assign M_ARBURST  = 2'b01;
  assign M_ARLOCK   = 2'b00;
  assign M_ARCACHE  = 4'b0000;
  assign M_ARPROT   = 3'b000;
  assign M_ARREGION = 4'b0000;
  assign M_ARQOS    = 4'b1111;
  assign M_ARVALID  = arvalid_q;

  assign M_RREADY        = in_seq && outdata_ready_i;
  assign outdata         = in_seq ? M_RDATA : '0;
  assign outdata_valid_o = in_seq && M_RVALID;
  assign data_last_o     = last_q;
  assign busy_o          = (state != RD_IDLE);

`ifdef AXI_DMA_RD_ERR_CHK_EN
  logic err_q;
  logic unused_rid;
  assign unused_rid = ^M_RID;

  // Sticky until the next accepted start; data keeps flowing regardless.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_q <= 1'b0;
    end else if ((state == RD_IDLE) && start_dma) begin
      err_q <= 1'b0;
    end else if (beat && ((M_RRESP != 2'b00) || (M_RLAST != beat_end))) begin
      err_q <= 1'b1;
    end
  end
  assign err_o = err_q;
`else
  logic unused_rsp;
  assign unused_rsp = ^{M_RID, M_RRESP, M_RLAST};
  assign err_o = 1'b0;
`endif

endmodule

// File: doc/axi_dma_rd.md
Name: axi_dma_rd

Overview:
- AXI4 read-master DMA: fetches num_trans 32-bit words from external memory, starting at start_addr, and streams them to a local consumer.
- Issues INCR bursts of FIXED_BURST_SIZE beats, with a shorter final burst for any remainder.
- Sits beside axi_dma_wr on the same AXI interconnect; loads YOLO parameters and feature data into on-chip buffers.

Parameters:
- M_AXI_ID_WIDTH, 4, AXI ID width.
- M_AXI_ADDR_WIDTH, 32, AXI address width.
- M_AXI_DATA_WIDTH, 32, AXI data width. Only 32 is supported.
- BITS_TRANS, 18, width of the word counters.
- FIXED_BURST_SIZE, 16, beats per full burst. Legal range 1..256.
- M_W, 2, log2 of bytes per beat.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- M_ARID  out  M_AXI_ID_WIDTH  constant 0
- M_ARADDR  out  M_AXI_ADDR_WIDTH  burst start address
- M_ARLEN  out  8  beats minus 1
- M_ARSIZE  out  3  3'b010
- M_ARBURST  out  2  2'b01 (INCR)
- M_ARLOCK  out  2  0
- M_ARCACHE  out  4  0
- M_ARPROT  out  3  0
- M_ARREGION  out  4  0
- M_ARQOS  out  4  4'b1111
- M_ARVALID  out  1  address valid
- M_ARREADY  in  1  address ready
- M_RID  in  M_AXI_ID_WIDTH  ignored
- M_RDATA  in  M_AXI_DATA_WIDTH  read data
- M_RRESP  in  2  read response
- M_RLAST  in  1  last beat
- M_RVALID  in  1  data valid
- M_RREADY  out  1  data ready
- start_dma  in  1  single-cycle start pulse
- num_trans  in  BITS_TRANS  words to read
- start_addr  in  M_AXI_ADDR_WIDTH  byte address, 4-byte aligned
- outdata  out  M_AXI_DATA_WIDTH  word to consumer
- outdata_valid_o  out  1  outdata valid
- outdata_ready_i  in  1  consumer accepts
- data_last_o  out  1  one-cycle pulse when the transfer is complete
- busy_o  out  1  high whenever state != RD_IDLE
- err_o  out  1  sticky error (see Optional Feature)

Behaviour:
- Reset: state RD_IDLE. All outputs 0, except the constant AR fields.
- start_dma is sampled only in RD_IDLE. When sampled, num_trans and start_addr are registered into num_trans_d and addr_q; burst_cnt is cleared. start_dma in any other state is ignored.
- burst_len_q (9 bits) is registered every cycle as min(FIXED_BURST_SIZE, num_trans_d - burst_cnt). ARLEN = burst_len_q - 1.
- FSM states and transitions:
  - RD_IDLE: on start_dma -> RD_PRE.
  - RD_PRE:
    - If burst_cnt == num_trans_d: pulse data_last_o, clear burst_cnt, go to RD_IDLE.
    - Otherwise -> RD_START.
  - RD_START: ARVALID = 1, with ARADDR and ARLEN held stable. On ARREADY -> RD_SEQ.
  - RD_SEQ:
    - M_RREADY = outdata_ready_i (combinational). outdata = M_RDATA. outdata_valid_o = M_RVALID.
    - Each beat (RVALID && RREADY) increments beat_cnt.
    - On the beat where beat_cnt == burst_len_q - 1: beat_cnt <= 0, burst_cnt += burst_len_q, addr_q += burst_len_q << M_W, go to RD_PRE.
- Latency: start_dma at cycle N gives ARVALID at N+2. After the final beat, data_last_o pulses 1 cycle later.
- Only one burst is outstanding at a time. No 4KB boundary splitting; software aligns buffers.
- num_trans == 0: data_last_o pulses at N+1, with no AR issued.
- Backpressure: with outdata_ready_i low, RREADY is low and no beat is counted.
- Burst termination is by beat count. M_RLAST is ignored unless the optional feature is enabled.
- Reset mid-transfer: immediate return to RD_IDLE; outstanding AXI beats are abandoned.

Optional Feature:
- Macro: AXI_DMA_RD_ERR_CHK_EN.
- Defined:
  - err_o is set when an accepted beat has RRESP != OKAY.
  - err_o is also set when RLAST disagrees with beat_cnt == burst_len_q - 1.
  - err_o is sticky until the next accepted start_dma.
  - Data is still forwarded and the transfer completes normally.
- Undefined: err_o tied 0; no RRESP or RLAST logic is built.

Test Plan:
- num_trans=40, start_addr=0x1000, slave always ready -> three AR handshakes at 0x1000/0x1040/0x1080 with ARLEN 15/15/7; 40 words in order; one data_last_o pulse.
- num_trans=0 -> no ARVALID; data_last_o pulses 1 cycle after start_dma; busy_o high for 1 cycle.
- num_trans=16, outdata_ready_i toggling 1/0 every cycle, random RVALID gaps -> exactly 16 accepted words, no duplicates or drops; RREADY equals outdata_ready_i throughout.
- start_dma pulsed again during RD_SEQ with num_trans=5 -> ignored; the original transfer completes unchanged.
- rstn asserted in RD_SEQ after 3 beats -> all outputs 0 immediately; a new start_dma with num_trans=4 runs cleanly.
- AXI_DMA_RD_ERR_CHK_EN defined, beat 2 returns RRESP=2'b10 -> err_o rises after beat 2 and stays high through data_last_o; it clears on the next start_dma.
